// File: rtl/mem_bus_pkg.sv
// Shared types and lane helpers for the byte-access bus initiator.
// Word-aligned bus, four byte lanes, little-endian lane numbering.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int LANES  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  // Byte offset to one-hot write strobe.
  function automatic logic [3:0] lane_strobe(
    input logic [1:0] off
  );
    logic [3:0] s;
    s = 4'b0000;
    unique case (off)
      2'd0: s = 4'b0001;
      2'd1: s = 4'b0010;
      2'd2: s = 4'b0100;
      2'd3: s = 4'b1000;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  // Pull the addressed byte out of a bus word.
  function automatic logic [7:0] lane_extract(
    input logic [31:0] w,
    input logic [1:0]  off
  );
    logic [7:0] b;
    b = 8'h00;
    unique case (off)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      2'd3: b = w[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Place a byte in its lane; other lanes stay zero.
  function automatic logic [31:0] lane_insert(
    input logic [7:0] b,
    input logic [1:0] off
  );
    logic [31:0] w;
    w = 32'h0;
    unique case (off)
      2'd0: w = {24'h0, b};
      2'd1: w = {16'h0, b, 8'h0};
      2'd2: w = {8'h0, b, 16'h0};
      2'd3: w = {b, 24'h0};
      default: w = 32'h0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_bus_initiator.sv
// Byte read/write command to one word-aligned bus transaction.
// Single-issue, registered outputs, optional bus-wait timeout.
module mem_bus_initiator
  import mem_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic        cmd_we,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  // Counter value seen on the edge that expires the wait.
  localparam logic [TO_W-1:0] TO_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : TO_W'(TIMEOUT_CYCLES - 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  state_t          state;
  logic [1:0]      off_q;
  logic            we_q;
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
  logic            to_sat;

  // Wait expires on the TIMEOUT_CYCLES-th edge spent in BUS.
  assign to_hit = TO_EN && (to_cnt == TO_LAST);
  assign to_sat = &to_cnt;

  // Main control: accept, hold bus request, then present response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      off_q     <= 2'd0;
      we_q      <= 1'b0;
      to_cnt    <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_err   <= 1'b0;
      mem_valid <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_wstrb <= 4'b0000;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            off_q     <= cmd_addr[1:0];
            we_q      <= cmd_we;
            to_cnt    <= '0;
            cmd_ready <= 1'b0;
            rsp_rdata <= 8'h00;
            rsp_err   <= 1'b0;
            mem_valid <= 1'b1;
            mem_addr  <= {cmd_addr[31:2], 2'b00};
            mem_wdata <= cmd_we
                       ? lane_insert(cmd_wdata, cmd_addr[1:0])
                       : 32'h0;
            mem_wstrb <= cmd_we
                       ? lane_strobe(cmd_addr[1:0])
                       : 4'b0000;
            state     <= BUS;
          end
        end
        BUS: begin
          // Completion is checked first so it beats a same-edge timeout.
          if (mem_ready) begin
            mem_valid <= 1'b0;
            mem_wstrb <= 4'b0000;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= we_q
                       ? 8'h00
                       : lane_extract(mem_rdata, off_q);
            state     <= RESP;
          end else if (to_hit) begin
            mem_valid <= 1'b0;
            mem_wstrb <= 4'b0000;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= 8'h00;
            state     <= RESP;
          end else if (!to_sat) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 8'h00;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          mem_valid <= 1'b0;
          mem_wstrb <= 4'b0000;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Directed bench for mem_bus_initiator (timeout set to 8 cycles).
// Inputs change and outputs are sampled on the falling edge.
module tb_mem_bus_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = 32'h0;
  logic        cmd_we = 1'b0;
  logic [7:0]  cmd_wdata = 8'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ready = 1'b0;

  int errs   = 0;
  int checks = 0;
  logic [31:0] gpio_word = 32'h0;
  logic [7:0]  lane_b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  always #5 clk = ~clk;

  mem_bus_initiator #(
    .TIMEOUT_CYCLES(8),
    .TO_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr),
    .cmd_we(cmd_we),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_valid(mem_valid),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  // Present a command; returns on the falling edge after acceptance.
  task automatic issue(
    input logic        we,
    input logic [31:0] a,
    input logic [7:0]  d
  );
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("accept_wait", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Responder: ready after dly wait cycles; counts mem_valid cycles.
  task automatic bus(
    input  int          dly,
    input  logic [31:0] word,
    input  logic [31:0] ea,
    input  logic [31:0] ew,
    input  logic [3:0]  es,
    output int          hi
  );
    logic bad;
    bad = 1'b0;
    hi  = 0;
    for (int i = 0; i < dly; i++) begin
      if (mem_valid) hi++;
      if (mem_addr !== ea || mem_wdata !== ew || mem_wstrb !== es)
        bad = 1'b1;
      mem_ready = 1'b0;
      @(negedge clk);
    end
    if (mem_valid) hi++;
    if (mem_addr !== ea || mem_wdata !== ew || mem_wstrb !== es)
      bad = 1'b1;
    for (int l = 0; l < 4; l++)
      if (mem_wstrb[l]) gpio_word[8*l +: 8] = mem_wdata[8*l +: 8];
    mem_rdata = word;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("fields_stable", 32'(bad), 32'd0);
  endtask

  // Check and consume a response.
  task automatic rsp(
    input string      tag,
    input logic [7:0] er,
    input logic       ee
  );
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_rdata"}, 32'(rsp_rdata), 32'(er));
    chk({tag, "_err"}, 32'(rsp_err), 32'(ee));
    chk({tag, "_mem_valid_lo"}, 32'(mem_valid), 32'd0);
    chk({tag, "_wstrb_lo"}, 32'(mem_wstrb), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_rsp_clr"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int n;
    logic bad;

    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_outs", {rsp_rdata, 3'b0, rsp_err, mem_wstrb, 16'h0},
        32'h0);
    chk("rst_addr", mem_addr | mem_wdata, 32'h0);
    rst = 1'b0;

    // Write 0xAA to byte 2 of word 0x100.
    issue(1'b1, 32'h0000_0102, 8'hAA);
    chk("wr_mem_valid", 32'(mem_valid), 32'd1);
    chk("wr_addr", mem_addr, 32'h0000_0100);
    chk("wr_wstrb", 32'(mem_wstrb), 32'h4);
    chk("wr_wdata", mem_wdata, 32'h00AA_0000);
    bus(0, 32'h0, 32'h100, 32'h00AA_0000, 4'b0100, hi);
    chk("wr_min_lat", 32'(hi), 32'd1);
    rsp("wr", 8'h00, 1'b0);

    // Read it back through the GPIO model.
    issue(1'b0, 32'h0000_0102, 8'h00);
    chk("rb_wstrb", 32'(mem_wstrb), 32'h0);
    bus(1, gpio_word, 32'h100, 32'h0, 4'b0000, hi);
    rsp("rb", 8'hAA, 1'b0);

    // Lane extraction at each offset.
    for (int o = 0; o < 4; o++) begin
      issue(1'b0, 32'h0000_0200 + 32'(o), 8'h00);
      bus(0, 32'h4433_2211, 32'h200, 32'h0, 4'b0000, hi);
      rsp($sformatf("lane%0d", o), lane_b[o], 1'b0);
    end

    // Slow responder: 5 wait cycles, 6 request cycles.
    issue(1'b1, 32'h0000_0301, 8'h5C);
    bus(5, 32'h0, 32'h300, 32'h0000_5C00, 4'b0010, hi);
    chk("slow_hi", 32'(hi), 32'd6);
    rsp("slow", 8'h00, 1'b0);

    // Ready on the same edge the wait would expire.
    issue(1'b0, 32'h0000_0303, 8'h00);
    bus(7, 32'hA1B2_C3D4, 32'h300, 32'h0, 4'b0000, hi);
    chk("edge_hi", 32'(hi), 32'd8);
    rsp("edge", 8'hA1, 1'b0);

    // Never ready: timeout after 8 cycles.
    issue(1'b0, 32'h0000_0010, 8'h00);
    mem_rdata = 32'hFFFF_FFFF;
    n = 0;
    while (mem_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("to_cycles", 32'(n), 32'd8);
    rsp("to", 8'h00, 1'b1);
    issue(1'b0, 32'h0000_0011, 8'h00);
    bus(0, 32'h0000_BB00, 32'h10, 32'h0, 4'b0000, hi);
    rsp("after_to", 8'hBB, 1'b0);

    // Response held off while the next command waits.
    issue(1'b1, 32'h0000_0004, 8'h12);
    bus(0, 32'h0, 32'h4, 32'h0000_0012, 4'b0001, hi);
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_addr  = 32'h0000_0008;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cmd_ready || mem_valid || !rsp_valid) bad = 1'b1;
      @(negedge clk);
    end
    chk("hold_blocked", 32'(bad), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("hold_idle_gap", 32'(mem_valid), 32'd0);
    chk("hold_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("hold_accept", 32'(mem_valid), 32'd1);
    chk("hold_addr", mem_addr, 32'h0000_0008);
    bus(0, 32'h0000_00EE, 32'h8, 32'h0, 4'b0000, hi);
    rsp("hold", 8'hEE, 1'b0);

    // Asynchronous reset during BUS.
    issue(1'b1, 32'h0000_0007, 8'h99);
    chk("ar_wstrb_pre", 32'(mem_wstrb), 32'h8);
    #2 rst = 1'b1;
    #1;
    chk("ar_mem_valid", 32'(mem_valid), 32'd0);
    chk("ar_wstrb", 32'(mem_wstrb), 32'd0);
    chk("ar_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ar_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("ar_idle", 32'(mem_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_initiator.md
# mem_bus_initiator

Hardware byte-access initiator for the word-aligned memory bus used by the GPIO and other peripherals. It accepts single-byte read/write commands over a valid/ready interface and converts each into one word-aligned bus transaction with the correct byte strobe and byte lane. For reads it extracts the addressed byte from the returned word, and it reports a timeout error if the responder never asserts `mem_ready`. It sits between on-chip command sources (debug bridge, test sequencer) and the peripheral bus, performing the bus-side role a CPU normally plays.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 255: bus-wait limit in cycles. 0 disables the timeout.
- `TO_W`, default 8: width of the timeout counter. Must satisfy TIMEOUT_CYCLES < 2^TO_W.

Ports:
- `clk`  in  1  single clock. All logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  a command is presented.
- `cmd_ready`  out  1  block can accept a command (high only in IDLE).
- `cmd_addr`  in  32  byte address.
- `cmd_we`  in  1  1 = write, 0 = read.
- `cmd_wdata`  in  8  write byte.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_rdata`  out  8  read byte. 0 for writes and on error.
- `rsp_err`  out  1  transaction timed out.
- `mem_valid`  out  1  bus request.
- `mem_addr`  out  32  word address {cmd_addr[31:2], 2'b00}.
- `mem_wdata`  out  32  write byte replicated only into lane cmd_addr[1:0]; other lanes 0.
- `mem_wstrb`  out  4  one-hot 1<<cmd_addr[1:0] for writes, 4'b0000 for reads.
- `mem_rdata`  in  32  read word from responder.
- `mem_ready`  in  1  responder completion.

## Operation

- States:
  - IDLE: cmd_ready=1. On cmd_valid, capture address, lane offset, we and data, drive the mem_* registers, then go to BUS.
  - BUS: mem_valid=1 with stable mem_addr, mem_wdata and mem_wstrb.
    - mem_ready=1 → capture mem_rdata lane [8*off+7 : 8*off] into rsp_rdata (reads only), go to RESP.
    - Timeout counter reaches TIMEOUT_CYCLES → set rsp_err=1 and rsp_rdata=0, go to RESP.
  - RESP: rsp_valid=1. mem_valid=0 and mem_wstrb=0. On rsp_ready → IDLE, clearing rsp_valid and rsp_err.
- Request fields must not change while mem_valid=1.
- mem_ready while mem_valid=0 is ignored.
- Completion wins over timeout: mem_ready on the same cycle the counter hits the limit completes normally with rsp_err=0.
- The timeout counter clears on entry to BUS and saturates, with no wrap.
- Exactly one bus transaction per accepted command. There is no retry after a timeout.
- A cmd_valid that arrives while not in IDLE is not accepted; the source must hold it.

## Timing

- Reset values: all outputs are 0 except cmd_ready, which is 1. State is IDLE.
- Reset asserted mid-transaction: mem_valid drops immediately (asynchronously). Any pending response is discarded.
- Accept edge N: mem_valid is high after edge N.
- Completion edge: the first edge M > N with mem_ready=1. mem_valid is low and rsp_valid is high after edge M.
  - The minimum command-to-response latency is 1 cycle, against a combinational-ready responder.
  - A registered-ready responder gives 2 cycles.
- Timeout: with no mem_ready, rsp_err is asserted after edge N+TIMEOUT_CYCLES.
- The next command is accepted no earlier than the edge after the rsp handshake. There is one cycle of IDLE between transactions.

## Structure

- Shared package `mem_bus_pkg` holds:
  - the state enum (IDLE, BUS, RESP);
  - the lane-strobe function (offset → one-hot wstrb);
  - the lane-extract and lane-insert functions.
- Peripheral addresses come from the existing memory-map header.
- Single module. No sub-module is warranted.

## Test plan

- Write cmd_addr=0x00000102, cmd_wdata=0xAA against a GPIO responder → mem_addr=0x00000100, mem_wstrb=4'b0100, mem_wdata=0x00AA0000, rsp_valid=1, rsp_err=0. A subsequent read of the same address gives rsp_rdata=0xAA.
- Read at each offset 0–3 with the responder returning 0x44332211 → rsp_rdata is 0x11, 0x22, 0x33, 0x44 respectively, and mem_wstrb=0 throughout.
- Responder holds mem_ready low for 5 cycles, with TIMEOUT_CYCLES=255 → mem_valid is high for exactly 6 cycles, fields are stable, and rsp_err=0.
- Responder never ready, with TIMEOUT_CYCLES=8 → rsp_err=1 and rsp_rdata=0 after 8 cycles, mem_valid=0, and the next command is accepted and completes normally.
- Hold rsp_ready low for 4 cycles while cmd_valid stays high → cmd_ready=0 and no second mem_valid until the rsp handshake completes.
- Assert rst while in BUS → mem_valid, rsp_valid and mem_wstrb drop asynchronously and cmd_ready=1 after reset release.
